// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Ports: clk, rst (async, active-high); hazard inputs id_rs, id_rt,
//   id_uses_rt, idex_memread, idex_rt, ex_branch_taken, ex_jump,
//   mem_busy, halt_req; latch controls pc_en, ifid_en, ifid_flush,
//   idex_en, idex_bubble, exmem_en; status halted, stall_count,
//   flush_count.
module pipeline_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_busy,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] drain_cnt;
   logic [2:0] drain_cnt_nxt;
   logic       lu;
   logic       rd;
   logic       stall_inc;
   logic       flush_inc;

   // $zero is never a real dependence, so rt==0 cannot stall.
   assign lu = idex_memread && (idex_rt != 5'd0) &&
               ((idex_rt == id_rs) ||
                (id_uses_rt && (idex_rt == id_rt)));
   assign rd = ex_branch_taken || ex_jump;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= 3'd0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      unique case (state)
         RUN, DRAIN: begin
            if (mem_busy) begin
               stall_inc = 1'b1;
            end else if (rd) begin
               flush_inc = 1'b1;
            end else if (lu) begin
               stall_inc = 1'b1;
            end else if (state == RUN) begin
               if (halt_req) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = 3'd0;
               end
            end else begin
               if (drain_cnt == DRAIN_LAST) begin
                  state_nxt = HALTED;
               end else begin
                  drain_cnt_nxt = drain_cnt + 3'd1;
               end
            end
         end
         HALTED: begin
            if (!halt_req) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt     = RUN;
            drain_cnt_nxt = 3'd0;
         end
      endcase
   end

   // Output logic; reset holds the pipeline empty.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
      if (rst) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         unique case (state)
            RUN, DRAIN: begin
               if (mem_busy) begin
                  pc_en = 1'b0;
               end else if (rd) begin
                  // Redirect also wins in DRAIN so PC keeps the target.
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_en    = 1'b1;
               end else if (lu) begin
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_en    = 1'b1;
               end else if (state == RUN) begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
               end else begin
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
               end
            end
            default: begin
               pc_en = 1'b0;
            end
         endcase
      end
   end

   // Status registers; counters stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted      <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         halted <= (state == HALTED);
         if (stall_inc && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
         if (flush_inc && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed steps plus random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int DC = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic [4:0]    id_rs;
   logic [4:0]    id_rt;
   logic          id_uses_rt;
   logic          idex_memread;
   logic [4:0]    idex_rt;
   logic          ex_branch_taken;
   logic          ex_jump;
   logic          mem_busy;
   logic          halt_req;
   logic          pc_en;
   logic          ifid_en;
   logic          ifid_flush;
   logic          idex_en;
   logic          idex_bubble;
   logic          exmem_en;
   logic          halted;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;
   logic [5:0]    ctrl;

   int errors = 0;
   int checks = 0;

   // Behavioural model: 0=run 1=drain 2=halted
   int m_state;
   int m_cnt;
   int m_halted;
   int m_stall;
   int m_flush;

   pipeline_hazard_ctrl #(
      .DRAIN_CYCLES(DC),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_uses_rt(id_uses_rt),
      .idex_memread(idex_memread),
      .idex_rt(idex_rt),
      .ex_branch_taken(ex_branch_taken),
      .ex_jump(ex_jump),
      .mem_busy(mem_busy),
      .halt_req(halt_req),
      .pc_en(pc_en),
      .ifid_en(ifid_en),
      .ifid_flush(ifid_flush),
      .idex_en(idex_en),
      .idex_bubble(idex_bubble),
      .exmem_en(exmem_en),
      .halted(halted),
      .stall_count(stall_count),
      .flush_count(flush_count)
   );

   assign ctrl = {pc_en, ifid_en, ifid_flush,
                  idex_en, idex_bubble, exmem_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic bit m_lu();
      return idex_memread && idex_rt != 0 &&
             (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
   endfunction

   function automatic bit m_rd();
      return ex_branch_taken || ex_jump;
   endfunction

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
   function automatic logic [5:0] m_ctrl();
      if (m_state == 2) return 6'b000000;
      if (mem_busy)     return 6'b000000;
      if (m_rd())       return 6'b111111;
      if (m_lu())       return 6'b000111;
      if (m_state == 0) return 6'b110101;
      return 6'b011101;
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic m_edge();
      m_halted = (m_state == 2);
      if (m_state == 2) begin
         if (!halt_req) m_state = 0;
      end else if (mem_busy) begin
         m_stall = sat(m_stall);
      end else if (m_rd()) begin
         m_flush = sat(m_flush);
      end else if (m_lu()) begin
         m_stall = sat(m_stall);
      end else if (m_state == 0) begin
         if (halt_req) begin
            m_state = 1;
            m_cnt   = 0;
         end
      end else if (m_cnt == DC - 1) begin
         m_state = 2;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic m_reset();
      m_state  = 0;
      m_cnt    = 0;
      m_halted = 0;
      m_stall  = 0;
      m_flush  = 0;
   endtask

   task automatic clear_in();
      id_rs           = 0;
      id_rt           = 0;
      id_uses_rt      = 0;
      idex_memread    = 0;
      idex_rt         = 0;
      ex_branch_taken = 0;
      ex_jump         = 0;
      mem_busy        = 0;
      halt_req        = 0;
   endtask

   // Called at a negedge with inputs already set.
   task automatic step(input string tag);
      #1;
      chk({tag, " ctrl"}, 32'(ctrl), 32'(m_ctrl()));
      chk({tag, " halted"}, 32'(halted), 32'(m_halted));
      chk({tag, " stall"}, 32'(stall_count), 32'(m_stall));
      chk({tag, " flush"}, 32'(flush_count), 32'(m_flush));
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   // Asynchronous reset applied between edges.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      m_reset();
      #1;
      chk({tag, " rst ctrl"}, 32'(ctrl), 32'h0A);
      chk({tag, " rst halted"}, 32'(halted), 32'd0);
      chk({tag, " rst stall"}, 32'(stall_count), 32'd0);
      chk({tag, " rst flush"}, 32'(flush_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int k;
      int base;
      rst = 1'b1;
      clear_in();
      m_reset();
      @(negedge clk);
      do_reset("init");

      // Load-use: one bubble, then load has moved on
      idex_memread = 1; idex_rt = 5; id_rs = 5;
      step("lu");
      chk("lu stall 1", 32'(stall_count), 32'd1);
      clear_in();
      step("lu after");

      // $zero dependence never stalls
      idex_memread = 1; idex_rt = 0; id_rs = 0;
      #1 chk("zero ctrl", 32'(ctrl), 32'h35);
      step("zero");

      // Redirect beats load-use
      do_reset("rdlu");
      idex_memread = 1; idex_rt = 7; id_rt = 7; id_uses_rt = 1;
      ex_branch_taken = 1;
      step("rdlu");
      chk("rdlu flush", 32'(flush_count), 32'd1);
      chk("rdlu stall", 32'(stall_count), 32'd0);
      clear_in();

      // Memory wait with a pending redirect
      do_reset("busy");
      ex_jump = 1; mem_busy = 1;
      for (int i = 0; i < 3; i++) step("busy");
      chk("busy stall 3", 32'(stall_count), 32'd3);
      mem_busy = 0;
      step("busy rd");
      chk("busy flush 1", 32'(flush_count), 32'd1);
      clear_in();

      // Halt with one freeze cycle inside DRAIN
      halt_req = 1;
      step("halt req");
      k = 0;
      for (int i = 0; i < 20; i++) begin
         mem_busy = (i == 1);
         step("drain");
         k++;
         if (halted === 1'b1) break;
      end
      mem_busy = 0;
      chk("halt latency", 32'(k), 32'd6);
      step("halted hold");
      halt_req = 0;
      ex_jump = 1;
      step("resume");
      ex_jump = 0;
      #1 chk("resume pc_en", 32'(pc_en), 32'd1);
      step("run again");

      // Reset in the middle of DRAIN
      halt_req = 1;
      step("halt2");
      step("drain2");
      step("drain2");
      do_reset("mid drain");
      clear_in();
      step("post rst");

      // Counter saturation
      idex_memread = 1; idex_rt = 5; id_rs = 5;
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat stall", 32'(stall_count), 32'(CMAX));
      clear_in();

      // Random traffic
      do_reset("rand");
      for (int i = 0; i < 400; i++) begin
         idex_memread    = 1'($urandom % 2);
         idex_rt         = 5'($urandom % 4);
         id_rs           = 5'($urandom % 4);
         id_rt           = 5'($urandom % 4);
         id_uses_rt      = 1'($urandom % 2);
         ex_branch_taken = ($urandom % 7) == 0;
         ex_jump         = ($urandom % 11) == 0;
         mem_busy        = ($urandom % 6) == 0;
         if (($urandom % 12) == 0) halt_req = ~halt_req;
         if (($urandom % 150) == 0) begin
            do_reset("rand rst");
         end
         step("rand");
      end
      base = checks;
      if (base < 12) chk("check count", 32'(base), 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM latches. It resolves load-use hazards, taken-branch/jump redirects and data-memory wait states. It also implements a halt/drain sequence that empties the pipeline before stopping, and keeps saturating stall and flush statistics.

## Interface
- DRAIN_CYCLES, 4: bubble cycles issued in DRAIN before entering HALTED (1..7).
- CNT_W, 16: width of the statistics counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID (IF/ID bits 25:21).
- id_rt  in  5  rt field of the instruction in ID (IF/ID bits 20:16).
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- idex_memread  in  1  MemRead of the instruction currently in ID/EX.
- idex_rt  in  5  rt destination of the instruction currently in ID/EX.
- ex_branch_taken  in  1  branch in EX is resolved taken.
- ex_jump  in  1  jump in EX.
- mem_busy  in  1  data memory not ready; pipeline must freeze.
- halt_req  in  1  level request to drain and halt.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP instead of the fetched word.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads all-zero control fields (branch, jump, MemRead, MemWrite, RegWrite).
- exmem_en  out  1  EX/MEM load enable.
- halted  out  1  registered; 1 while in HALTED.
- stall_count  out  CNT_W  saturating count of stall cycles (load-use plus mem_busy).
- flush_count  out  CNT_W  saturating count of redirects.

## Operation
- States: RUN, DRAIN, HALTED. drain_cnt is 3 bits wide.
- Control outputs are combinational from state and inputs. halted and the counters are registered.
- Load-use hazard (LU): idex_memread and idex_rt≠0 and (idex_rt==id_rs, or id_uses_rt and idex_rt==id_rt).
- Redirect (RD): ex_branch_taken or ex_jump.
- Priority in RUN and DRAIN: mem_busy > RD > LU > default.
- mem_busy=1 (freeze):
  - All four enables are 0; ifid_flush=0; idex_bubble=0.
  - State and drain_cnt hold; stall_count increments.
  - The branch in EX stays frozen and re-asserts RD afterwards, so nothing is latched.
- RD:
  - pc_en, ifid_en, idex_en and exmem_en are 1; ifid_flush=1; idex_bubble=1.
  - flush_count increments.
  - Valid in DRAIN too, so the PC holds the target across the halt.
  - drain_cnt holds during RD.
- LU:
  - pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1.
  - stall_count increments; drain_cnt holds.
- Default RUN: all enables 1, ifid_flush=0, idex_bubble=0.
  - If halt_req=1, go to DRAIN with drain_cnt=0 (that cycle still advances normally).
- Default DRAIN:
  - pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=0, exmem_en=1.
  - drain_cnt increments; at drain_cnt==DRAIN_CYCLES-1, go to HALTED.
  - halt_req dropping during DRAIN does not abort it.
- HALTED:
  - All enables 0; flush and bubble 0; hazard inputs ignored.
  - halt_req=0 → RUN on the next edge.
- Counters saturate at all-ones and never wrap. They clear only on rst.

## Timing
- Reset (asynchronous, while rst=1):
  - State RUN; drain_cnt=0; halted=0; counters 0.
  - Outputs forced: enables 0, ifid_flush=1, idex_bubble=1, so the pipeline is held empty.
- First clk edge after rst falls: normal RUN operation.
- LU costs exactly one bubble cycle: on the next cycle the load has moved to EX/MEM and LU clears.
- RD costs two squashed instructions (IF/ID and ID/EX) and zero extra cycles.
- Halt latency: halt_req seen in default RUN at edge N → halted=1 after edge N+1+DRAIN_CYCLES, when no stalls occur. Each stall/freeze cycle adds one.
- Resume: halt_req=0 in HALTED → pc_en=1 in the following cycle.
- Simultaneous RD and LU: RD wins, because the LU instruction is squashed; only flush_count increments.

## Test plan
- Load-use stall:
  - Stimulus: idex_memread=1, idex_rt=5, id_rs=5, no other events.
  - Response: exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_count 0→1.
- $zero dependence:
  - Stimulus: idex_memread=1, idex_rt=0, id_rs=0.
  - Response: no stall; all enables 1.
- Branch taken with simultaneous LU:
  - Stimulus: ex_branch_taken=1 in the same cycle as a load-use condition.
  - Response: ifid_flush=1, idex_bubble=1, pc_en=1; flush_count=1; stall_count=0.
- Memory wait:
  - Stimulus: mem_busy=1 for 3 cycles during RUN with RD asserted.
  - Response: all enables 0 for 3 cycles; stall_count=3; RD honored in the cycle mem_busy falls.
- Halt/drain:
  - Stimulus: halt_req=1 with DRAIN_CYCLES=4; one mem_busy cycle during DRAIN.
  - Response: halted=1 six edges after the request edge; then halt_req=0 → RUN with pc_en=1.
- Reset and saturation:
  - Stimulus: rst mid-DRAIN → state RUN, halted=0, counters 0, enables 0, ifid_flush=1 immediately (asynchronous).
  - Stimulus: with CNT_W=4, hold LU continuously for 20 cycles.
  - Response: stall_count sticks at 15.
